// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared load/store encodings and responder state type
// Purpose: RV32I funct3 codes for memory ops, lane/byte-enable widths and the
//   responder state enum. The core's control unit imports the same package.
// Ports: none (package).
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int LANE_W = 2;
  localparam int BE_W   = 4;

  // ST_ACCESS is the single edge where the RAM is read or written and the
  // response registers are loaded; it follows the optional wait states.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_RESP
  } mem_state_e;

endpackage

// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - load/store request/response bundle
// Purpose: groups the request and response handshakes of the data port.
// Ports (signals):
//   req_valid/req_ready, req_we, req_funct3[2:0], req_addr[31:0], req_wdata[31:0]
//   resp_valid/resp_ready, resp_rdata[31:0], resp_err
// Modports: master = requester (core or bridge), slave = memory responder.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane steering and RV32I load extension
// Purpose: combinational helper that turns funct3 + lane into byte enables and
//   replicated store data, and selects/extends the addressed bytes of a RAM word.
// Ports:
//   we       in  1   store (1) or load (0)
//   funct3   in  3   RV32I memory funct3
//   lane     in  2   addr[1:0]
//   wdata    in  32  right-aligned store data
//   raw      in  32  RAM word at the addressed index
//   be       out 4   byte enables for a store
//   st_data  out 32  store data replicated into every lane
//   ld_data  out 32  sign/zero-extended load result
//   misalign out 1   half not on even address or word not on 4-byte boundary
//   illegal  out 1   funct3 not valid for this direction
module mem_lane_align
  import mem_pkg::*;
(
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [LANE_W-1:0] lane,
  input  logic [31:0]       wdata,
  input  logic [31:0]       raw,
  output logic [BE_W-1:0]   be,
  output logic [31:0]       st_data,
  output logic [31:0]       ld_data,
  output logic              misalign,
  output logic              illegal
);

  logic [31:0] shifted;

  always_comb begin
    be       = '0;
    st_data  = '0;
    ld_data  = '0;
    misalign = 1'b0;
    illegal  = 1'b0;
    // Bring the addressed lane down to bit 0 so byte/half picks are fixed slices.
    shifted  = raw >> {lane, 3'b000};
    case (funct3)
      F3_B: begin
        be      = 4'b0001 << lane;
        st_data = {4{wdata[7:0]}};
        ld_data = {{24{shifted[7]}}, shifted[7:0]};
      end
      F3_H: begin
        be       = lane[1] ? 4'b1100 : 4'b0011;
        st_data  = {2{wdata[15:0]}};
        ld_data  = {{16{shifted[15]}}, shifted[15:0]};
        misalign = lane[0];
      end
      F3_W: begin
        be       = 4'b1111;
        st_data  = wdata;
        ld_data  = raw;
        misalign = |lane;
      end
      F3_BU: begin
        ld_data = {24'h0, shifted[7:0]};
        illegal = we;
      end
      F3_HU: begin
        ld_data  = {16'h0, shifted[15:0]};
        misalign = lane[0];
        illegal  = we;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word RAM responder for the core load/store port
// Purpose: accepts one request at a time, waits WAIT_CYCLES, performs a
//   byte/half/word access with RV32I extension, and holds the response until
//   the requester takes it.
// Ports:
//   clk  in  1   rising-edge clock
//   rst  in  1   synchronous active-high reset (RAM contents kept)
//   bus  slave modport of data_mem_responder_if
// Parameters: DEPTH (32-bit words, power of two), WAIT_CYCLES (0..15).
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  mem_state_e state, next_state;
  logic [3:0]  cnt;
  logic        do_accept, do_access;

  logic        l_we;
  logic [2:0]  l_f3;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;

  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH];

  logic [AW-1:0]     idx;
  logic [31:0]       raw;
  logic [31:0]       addr_hi;
  logic              range_err, acc_err;
  logic [BE_W-1:0]   be;
  logic [31:0]       st_data, ld_data;
  logic              misalign, illegal;

  assign idx       = l_addr[2 +: AW];
  assign raw       = mem[idx];
  // Any address bit above the RAM's word index is out of range; no aliasing.
  assign addr_hi   = l_addr >> (AW + 2);
  assign range_err = |addr_hi;
  assign acc_err   = misalign | illegal | range_err;

  mem_lane_align u_align (
    .we      (l_we),
    .funct3  (l_f3),
    .lane    (l_addr[1:0]),
    .wdata   (l_wdata),
    .raw     (raw),
    .be      (be),
    .st_data (st_data),
    .ld_data (ld_data),
    .misalign(misalign),
    .illegal (illegal)
  );

  assign bus.req_ready  = (state == ST_IDLE);
  assign bus.resp_valid = (state == ST_RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

  always_comb begin
    next_state = state;
    do_accept  = 1'b0;
    do_access  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          do_accept  = 1'b1;
          next_state = (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt == 4'd0) next_state = ST_ACCESS;
      end
      ST_ACCESS: begin
        do_access  = 1'b1;
        next_state = ST_RESP;
      end
      ST_RESP: begin
        if (bus.resp_ready) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state <= next_state;
      if (do_accept) begin
        cnt <= CNT_INIT;
      end else if (state == ST_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (do_access) begin
        err_q   <= acc_err;
        rdata_q <= (l_we || acc_err) ? 32'h0 : ld_data;
      end
    end
  end

  // Request fields are captured once; the requester may change them afterwards.
  always_ff @(posedge clk) begin
    if (do_accept && !rst) begin
      l_we    <= bus.req_we;
      l_f3    <= bus.req_funct3;
      l_addr  <= bus.req_addr;
      l_wdata <= bus.req_wdata;
    end
  end

  // RAM is outside the reset domain; a reset on the access edge blocks the write.
  always_ff @(posedge clk) begin
    if (!rst && do_access && l_we && !acc_err) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard bench for data_mem_responder
module tb_data_mem_responder;
  import mem_pkg::*;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  int          sel;
  logic        req_valid, req_we, resp_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        o_req_ready, o_resp_valid, o_err;
  logic [31:0] o_rdata;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  data_mem_responder_if bus0 ();
  data_mem_responder_if bus2 ();
  data_mem_responder_if bus3 ();

  assign bus0.req_valid  = req_valid && (sel == 0);
  assign bus0.resp_ready = resp_ready && (sel == 0);
  assign bus0.req_we     = req_we;
  assign bus0.req_funct3 = req_funct3;
  assign bus0.req_addr   = req_addr;
  assign bus0.req_wdata  = req_wdata;

  assign bus2.req_valid  = req_valid && (sel == 2);
  assign bus2.resp_ready = resp_ready && (sel == 2);
  assign bus2.req_we     = req_we;
  assign bus2.req_funct3 = req_funct3;
  assign bus2.req_addr   = req_addr;
  assign bus2.req_wdata  = req_wdata;

  assign bus3.req_valid  = req_valid && (sel == 3);
  assign bus3.resp_ready = resp_ready && (sel == 3);
  assign bus3.req_we     = req_we;
  assign bus3.req_funct3 = req_funct3;
  assign bus3.req_addr   = req_addr;
  assign bus3.req_wdata  = req_wdata;

  assign o_req_ready  = (sel == 3) ? bus3.req_ready  : (sel == 2) ? bus2.req_ready  : bus0.req_ready;
  assign o_resp_valid = (sel == 3) ? bus3.resp_valid : (sel == 2) ? bus2.resp_valid : bus0.resp_valid;
  assign o_rdata      = (sel == 3) ? bus3.resp_rdata : (sel == 2) ? bus2.resp_rdata : bus0.resp_rdata;
  assign o_err        = (sel == 3) ? bus3.resp_err   : (sel == 2) ? bus2.resp_err   : bus0.resp_err;

  data_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) u0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  data_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(2)) u2 (.clk(clk), .rst(rst), .bus(bus2.slave));
  data_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(3)) u3 (.clk(clk), .rst(rst), .bus(bus3.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic int wait_of(input int s);
    return (s == 3) ? 3 : (s == 2) ? 2 : 0;
  endfunction

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit hold);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    while (!o_req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!o_req_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if (!hold) begin
      req_valid = 1'b0;
      req_addr  = 32'hxxxx_xxxx;
      req_wdata = 32'hxxxx_xxxx;
    end
  endtask

  task automatic collect(input string tag, input int exp_lat);
    int   lat = 0;
    exp_t e;
    while (!o_resp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_rdata"}, o_rdata, e.rdata);
      chk({tag, "_err"}, {31'h0, o_err}, {31'h0, e.err});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rd, input logic exp_err);
    sb.push_back(exp_t'{rdata: exp_rd, err: exp_err});
    issue(we, f3, addr, wdata, 1'b0);
    collect(tag, 1 + wait_of(sel));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    bit   saw;
    rst = 1'b1; sel = 0; req_valid = 1'b0; req_we = 1'b0; resp_ready = 1'b1;
    req_funct3 = F3_W; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      if (s == 1) continue;
      sel = s;
      #1;
      chk("rst_req_ready", {31'h0, o_req_ready}, 32'd1);
      chk("rst_resp_valid", {31'h0, o_resp_valid}, 32'd0);
      chk("rst_rdata", o_rdata, 32'h0);
      chk("rst_err", {31'h0, o_err}, 32'd0);
    end
    sel = 0;

    xact("t1_sw", 1, F3_W, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    xact("t1_lw", 0, F3_W, 32'h10, 32'h0, 32'hDEADBEEF, 0);

    xact("t2_sb", 1, F3_B, 32'h13, 32'h0000007F, 32'h0, 0);
    xact("t2_lw", 0, F3_W, 32'h10, 32'h0, 32'h7FADBEEF, 0);
    xact("t2_lb", 0, F3_B, 32'h12, 32'h0, 32'hFFFFFFAD, 0);
    xact("t2_lbu", 0, F3_BU, 32'h12, 32'h0, 32'h000000AD, 0);

    xact("t3_sh", 1, F3_H, 32'h12, 32'hABCD8001, 32'h0, 0);
    xact("t3_lh", 0, F3_H, 32'h12, 32'h0, 32'hFFFF8001, 0);
    xact("t3_lhu", 0, F3_HU, 32'h12, 32'h0, 32'h00008001, 0);
    xact("t3_lh_mis", 0, F3_H, 32'h11, 32'h0, 32'h0, 1);
    xact("t3_lw_after", 0, F3_W, 32'h10, 32'h0, 32'h8001BEEF, 0);
    xact("t3_sw_mis", 1, F3_W, 32'h12, 32'h11223344, 32'h0, 1);
    xact("t3_sbu_ill", 1, F3_BU, 32'h10, 32'h55, 32'h0, 1);
    xact("t3_f3_ill", 0, 3'b011, 32'h10, 32'h0, 32'h0, 1);
    xact("t3_lw_keep", 0, F3_W, 32'h10, 32'h0, 32'h8001BEEF, 0);

    xact("t5_sw0", 1, F3_W, 32'h0, 32'hCAFEF00D, 32'h0, 0);
    xact("t5_lw_oor", 0, F3_W, 32'h00001000, 32'h0, 32'h0, 1);
    xact("t5_sw_oor", 1, F3_W, 32'h00001000, 32'h55555555, 32'h0, 1);
    xact("t5_lw0", 0, F3_W, 32'h0, 32'h0, 32'hCAFEF00D, 0);

    sel = 3;
    xact("t4_sw", 1, F3_W, 32'h40, 32'h12345678, 32'h0, 0);
    sb.push_back(exp_t'{rdata: 32'h12345678, err: 1'b0});
    sb.push_back(exp_t'{rdata: 32'h12345678, err: 1'b0});
    resp_ready = 1'b0;
    issue(0, F3_W, 32'h40, 32'h0, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      chk("t4_req_ready_wait", {31'h0, o_req_ready}, 32'd0);
      chk("t4_valid_rise", {31'h0, o_resp_valid}, 32'(i == 4));
    end
    e = sb.pop_front();
    chk("t4_rdata", o_rdata, e.rdata);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("t4_hold_valid", {31'h0, o_resp_valid}, 32'd1);
      chk("t4_hold_rdata", o_rdata, e.rdata);
      chk("t4_hold_ready", {31'h0, o_req_ready}, 32'd0);
    end
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("t4_idle_ready", {31'h0, o_req_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk("t4_accept2", {31'h0, o_req_ready}, 32'd0);
    req_valid = 1'b0;
    collect("t4_lw2", 4);

    sel = 2;
    xact("t6_sw_old", 1, F3_W, 32'h20, 32'h11111111, 32'h0, 0);
    xact("t6_lw_old", 0, F3_W, 32'h20, 32'h0, 32'h11111111, 0);
    issue(1, F3_W, 32'h20, 32'h22222222, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_rst_req_ready", {31'h0, o_req_ready}, 32'd1);
    chk("t6_rst_resp_valid", {31'h0, o_resp_valid}, 32'd0);
    chk("t6_rst_rdata", o_rdata, 32'h0);
    chk("t6_rst_err", {31'h0, o_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (o_resp_valid) saw = 1'b1;
    end
    chk("t6_no_resp", {31'h0, saw}, 32'd0);
    xact("t6_lw_after", 0, F3_W, 32'h20, 32'h0, 32'h11111111, 0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
